// File: rtl/reg_arb_pkg.sv
// Shared state encoding and default sizing for the register arbiter.
// No logic and no latency; the package carries no flow control.
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;
    localparam int HOLD_W       = 4;
    localparam int OWNER_W      = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit at or above ptr, wrapping modulo N_REQ.
// Purely combinational (zero latency); no flow control of its own.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             any_req
);

    always_comb begin
        int j;
        j       = 0;
        winner  = '0;
        any_req = |req;
        // Walk from the farthest offset down so the nearest hit to ptr wins.
        for (int off = N_REQ - 1; off >= 0; off--) begin
            j = int'(ptr) + off;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req[j]) begin
                winner = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter for a shared register with bounded lock; gnt registered, write lands two edges after req.
// Losers simply wait with req held; the winner may hold up to MAX_HOLD cycles before being forced off.
module reg_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [OWNER_W-1:0]     owner
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

    arb_state_e          state, state_nxt;
    logic [N_REQ-1:0]    gnt_r, gnt_nxt;
    logic [IW-1:0]       win, win_nxt;
    logic [IW-1:0]       ptr, ptr_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [WIDTH-1:0]    q_r, q_nxt;
    logic                qv_r, qv_nxt;
    logic [OWNER_W-1:0]  owner_r, owner_nxt;

    logic [N_REQ-1:0]    pick_req;
    logic [IW-1:0]       pick_ptr;
    logic [IW-1:0]       pick_win;
    logic                pick_any;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // While granted, the picker looks past the current winner for a handover.
    assign pick_req = (state == GRANT) ? (req & ~gnt_r) : req;
    assign pick_ptr = (state == GRANT) ? next_idx(win) : ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req     (pick_req),
        .ptr     (pick_ptr),
        .winner  (pick_win),
        .any_req (pick_any)
    );

    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        q_nxt     = q_r;
        qv_nxt    = 1'b0;
        owner_nxt = owner_r;
        gnt_nxt   = '0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    win_nxt   = pick_win;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (req[win]) begin
                    q_nxt     = data_in[int'(win)*WIDTH +: WIDTH];
                    owner_nxt = OWNER_W'(win);
                    qv_nxt    = 1'b1;
                end
                if (lock[win] && req[win] && (hold_cnt < HOLD_LIM)) begin
                    hold_nxt = hold_cnt + 1'b1;
                end else begin
                    ptr_nxt  = next_idx(win);
                    hold_nxt = '0;
                    if (pick_any) begin
                        win_nxt = pick_win;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt == GRANT) begin
            gnt_nxt = N_REQ'(1) << win_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt_r    <= '0;
            win      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            q_r      <= '0;
            qv_r     <= 1'b0;
            owner_r  <= '0;
        end else begin
            state    <= state_nxt;
            gnt_r    <= gnt_nxt;
            win      <= win_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            q_r      <= q_nxt;
            qv_r     <= qv_nxt;
            owner_r  <= owner_nxt;
        end
    end

    assign gnt     = gnt_r;
    assign q       = q_r;
    assign q_valid = qv_r;
    assign owner   = owner_r;

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed checks of reg_arbiter: reset, single write, fairness, lock limit, abort, async reset.
module tb_reg_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        q_valid;
    logic [2:0]  owner;

    int total;
    int bad;

    reg_arbiter #(
        .N_REQ    (4),
        .WIDTH    (8),
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .lock    (lock),
        .data_in (data_in),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int n_own0;
        int n_gnt0;
        logic [3:0] exp_gnt [5];
        logic [7:0] exp_q   [5];
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        req     = 4'b1111;
        lock    = 4'b0000;
        data_in = 32'h0;

        // Reset held for two edges with all requests asserted.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_q", 32'(q), 32'h0);
            chk("rst_qv", 32'(q_valid), 32'h0);
        end
        chk("rst_owner", 32'(owner), 32'h0);

        // Single requester 2.
        reset_n = 1'b1;
        req     = 4'b0100;
        data_in[2*8 +: 8] = 8'hA5;
        tick();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_qv_early", 32'(q_valid), 32'h0);
        tick();
        chk("single_q", 32'(q), 32'hA5);
        chk("single_owner", 32'(owner), 32'h2);
        chk("single_qv", 32'(q_valid), 32'h1);
        req = 4'b0000;
        tick();
        chk("single_qv_once", 32'(q_valid), 32'h0);
        chk("single_idle", 32'(gnt), 32'h0);
        chk("single_q_hold", 32'(q), 32'hA5);

        // Fairness with all four requesting, no lock.
        do_reset();
        for (int i = 0; i < 4; i++) data_in[i*8 +: 8] = 8'(8'h10 + i);
        req = 4'b1111;
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_q   = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("fair_gnt%0d", i), 32'(gnt), 32'(exp_gnt[i]));
            chk($sformatf("fair_q%0d", i), 32'(q), 32'(exp_q[i]));
        end

        // Lock limit: requester 0 locked, requester 1 waiting.
        do_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        data_in[0 +: 8] = 8'h20;
        data_in[8 +: 8] = 8'h21;
        n_own0 = 0;
        n_gnt0 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (gnt[0]) n_gnt0++;
            if (q_valid && owner == 3'd0) n_own0++;
        end
        chk("lock_gnt1", 32'(gnt), 32'h2);
        chk("lock_gnt0_cycles", 32'(n_gnt0), 32'd4);
        chk("lock_pulses0", 32'(n_own0), 32'd4);
        tick();
        chk("lock_q1", 32'(q), 32'h21);
        chk("lock_owner1", 32'(owner), 32'h1);
        chk("lock_back0", 32'(gnt), 32'h1);

        // Abort: requester 1 drops its request while granted.
        do_reset();
        lock = 4'b0000;
        req  = 4'b0001;
        data_in[0 +: 8] = 8'h33;
        tick();
        tick();
        chk("abort_pre_q", 32'(q), 32'h33);
        req = 4'b0010;
        data_in[8 +: 8] = 8'h55;
        tick();
        chk("abort_gnt1", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();
        chk("abort_q", 32'(q), 32'h33);
        chk("abort_owner", 32'(owner), 32'h0);
        chk("abort_qv", 32'(q_valid), 32'h0);
        chk("abort_idle", 32'(gnt), 32'h0);
        req = 4'b1111;
        tick();
        chk("abort_ptr2", 32'(gnt), 32'h4);

        // Asynchronous reset in the middle of a locked grant.
        do_reset();
        req  = 4'b0001;
        lock = 4'b0001;
        data_in[0 +: 8]  = 8'h44;
        data_in[24 +: 8] = 8'h77;
        tick();
        tick();
        chk("mid_pre_q", 32'(q), 32'h44);
        chk("mid_pre_gnt", 32'(gnt), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_gnt", 32'(gnt), 32'h0);
        chk("mid_q", 32'(q), 32'h0);
        chk("mid_qv", 32'(q_valid), 32'h0);
        chk("mid_owner", 32'(owner), 32'h0);
        req  = 4'b1000;
        lock = 4'b0000;
        #1;
        reset_n = 1'b1;
        tick();
        chk("mid_gnt3", 32'(gnt), 32'h8);
        tick();
        chk("mid_q3", 32'(q), 32'h77);
        chk("mid_owner3", 32'(owner), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
